mem_port_arbiter: RTL and testbench

- Round-robin arbiter and sequencer sharing one 128x8 single-port synchronous RAM among NUM_REQ requesters.
- Accepts one read or write per cycle, registers the winning command onto the RAM port, and routes the 1-cycle-latency read data back to the originating requester with a response strobe.
- Sits between client blocks (host interface, scratch engines) and the byte memory.

---
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Round-robin arbiter and sequencer that shares one 128x8 single-port
// synchronous RAM among NUM_REQ requesters. One command is accepted per
// cycle. The winning command is registered onto the RAM port. The
// one-cycle-latency read data is routed back to the requester that issued
// the command, together with a response strobe.
//
// Timing, with acceptance in cycle T:
//   T    req_ready[i] = 1 (combinational grant)
//   T+1  mem_en = 1; mem_wr/mem_addr/mem_wdata carry the winner's command
//   T+2  rsp_valid[i] = 1; rsp_rdata = mem_rdata (writes get an ack that
//        carries the RAM's old data)
//
// Ports:
//   clk           clock, all logic on the rising edge
//   rst           asynchronous, active-high reset
//   req_valid     per-requester command valid
//   req_ready     one-hot grant; a command is accepted on valid & ready
//   req_wr        per-requester write select (1 = write, 0 = read)
//   req_addr      packed addresses; requester i at [i*AW +: AW]
//   req_wdata     packed write data; requester i at [i*DW +: DW]
//   rsp_valid     one-cycle response strobe to the originating requester
//   rsp_rdata     response data on a shared bus, qualified by rsp_valid
//   mem_en        RAM access strobe
//   mem_wr        RAM write enable
//   mem_addr      RAM address
//   mem_wdata     RAM write data
//   mem_rdata     RAM read data, valid one cycle after mem_en
//   conflict_cnt  contention counter
//
// Build option:
//   ARB_PERF_EN   When this macro is defined, conflict_cnt counts the cycles
//                 in which a valid requester is denied while another
//                 requester is granted. The count saturates at 16'hFFFF.
//                 When the macro is undefined, conflict_cnt is tied to zero.

module mem_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int AW      = 7,
  parameter int DW      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_wr,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rdata,
  output logic [15:0]           conflict_cnt
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]      last_q;
  logic [NUM_REQ-1:0] rot_valid;
  int                 grant_off;
  logic               grant_any;
  logic [IW-1:0]      grant_idx;
  logic [NUM_REQ-1:0] grant_vec;

  logic               win_wr;
  logic [AW-1:0]      win_addr;
  logic [DW-1:0]      win_wdata;

  logic               stage1_valid;
  logic [IW-1:0]      stage1_idx;
  logic               stage2_valid;
  logic [IW-1:0]      stage2_idx;
  logic [DW-1:0]      rdata_hold;

  // Round-robin search. rot_valid[j] is the valid bit of requester
  // (last+1+j) mod NUM_REQ, so the lowest set bit is the next winner.
  always_comb begin
    rot_valid = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (((int'(last_q) + 1 + j) % NUM_REQ) == i) begin
          rot_valid[j] = req_valid[i];
        end
      end
    end

    grant_any = 1'b0;
    grant_off = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!grant_any && rot_valid[j]) begin
        grant_any = 1'b1;
        grant_off = j;
      end
    end
    grant_idx = IW'((int'(last_q) + 1 + grant_off) % NUM_REQ);

    // No grant may be issued while the block is held in reset.
    if (rst) begin
      grant_any = 1'b0;
    end

    grant_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_vec[i] = grant_any && (int'(grant_idx) == i);
    end
  end

  assign req_ready = grant_vec;

  always_comb begin
    win_wr    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vec[i]) begin
        win_wr    = req_wr[i];
        win_addr  = req_addr[i*AW +: AW];
        win_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // Command stage and response tag pipeline. The RAM register provides the
  // data stage, so the response strobe lines up with stage2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q       <= IW'(NUM_REQ - 1);
      mem_en       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      stage1_valid <= 1'b0;
      stage1_idx   <= '0;
      stage2_valid <= 1'b0;
      stage2_idx   <= '0;
      rdata_hold   <= '0;
    end else begin
      mem_en       <= grant_any;
      stage1_valid <= grant_any;
      if (grant_any) begin
        last_q     <= grant_idx;
        mem_wr     <= win_wr;
        mem_addr   <= win_addr;
        mem_wdata  <= win_wdata;
        stage1_idx <= grant_idx;
      end else begin
        mem_wr     <= 1'b0;
      end
      stage2_valid <= stage1_valid;
      stage2_idx   <= stage1_idx;
      if (stage2_valid) begin
        rdata_hold <= mem_rdata;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = stage2_valid && (int'(stage2_idx) == i);
    end
  end

  // The RAM output register is the data stage. It is passed straight
  // through during the response cycle. Between responses, rdata_hold keeps
  // the last delivered value on the bus.
  assign rsp_rdata = stage2_valid ? mem_rdata : rdata_hold;

`ifdef ARB_PERF_EN
  logic [15:0] conflict_q;
  logic        conflict_now;

  assign conflict_now = grant_any && (|(req_valid & ~grant_vec));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= '0;
    end else if (conflict_now && (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (NUM_REQ=2, AW=7, DW=8).
// Includes a read-before-write synchronous RAM model on the memory port.
// RAM contents at start: ram[a] = a + 8'h40, except ram[7'h05] = 8'hA5.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_wr;
  logic [13:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [6:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [15:0] conflict_cnt;

  logic [7:0]  ram [128];

  int n_cmp = 0;
  int n_err = 0;
  int exp_conf6;
  int exp_conf10;

  mem_port_arbiter #(.NUM_REQ(2), .AW(7), .DW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .mem_en       (mem_en),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      if (mem_wr) ram[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef ARB_PERF_EN
    exp_conf6  = 6;
    exp_conf10 = 10;
`else
    exp_conf6  = 0;
    exp_conf10 = 0;
`endif
    for (int i = 0; i < 128; i++) ram[i] = 8'(i + 8'h40);
    ram[7'h05] = 8'hA5;

    // Reset state: valid is asserted, but no grant may be issued.
    rst = 1'b1; req_valid = 2'b11; req_wr = 2'b00; req_addr = '0; req_wdata = '0;
    #2;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_addr", mem_addr, 7'h00);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_conflict", conflict_cnt, 16'h0000);
    req_valid = 2'b00;
    tick(); tick();
    rst = 1'b0;

    // Single read by requester 0.
    req_valid = 2'b01; req_addr[6:0] = 7'h05; #1;
    chk("t1_ready", req_ready, 2'b01);
    tick();
    chk("t1_mem_en", mem_en, 1'b1);
    chk("t1_mem_wr", mem_wr, 1'b0);
    chk("t1_mem_addr", mem_addr, 7'h05);
    chk("t1_rsp_early", rsp_valid, 2'b00);
    req_valid = 2'b00;
    tick();
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_rdata", rsp_rdata, 8'hA5);
    chk("t1_idle_en", mem_en, 1'b0);
    tick();
    chk("t1_rsp_off", rsp_valid, 2'b00);
    chk("t1_rdata_hold", rsp_rdata, 8'hA5);
    chk("t1_addr_hold", mem_addr, 7'h05);

    // Both requesters valid for 6 cycles after reset: grants must alternate 0,1,0,1,...
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin
        req_valid = 2'b11; req_addr[6:0] = 7'h0A; req_addr[13:7] = 7'h14;
      end else begin
        req_valid = 2'b00;
      end
      #1;
      if (c < 6) chk("t2_ready", req_ready, (c % 2) ? 2'b10 : 2'b01);
      if (c >= 1 && c <= 6) begin
        chk("t2_mem_en", mem_en, 1'b1);
        chk("t2_mem_addr", mem_addr, ((c - 1) % 2) ? 7'h14 : 7'h0A);
      end
      if (c == 7) chk("t2_mem_en_off", mem_en, 1'b0);
      if (c >= 2) begin
        chk("t2_rsp_valid", rsp_valid, ((c - 2) % 2) ? 2'b10 : 2'b01);
        chk("t2_rsp_rdata", rsp_rdata, ((c - 2) % 2) ? 8'h54 : 8'h4A);
      end
      tick();
    end
    chk("t2_rsp_off", rsp_valid, 2'b00);
    chk("t2_conflict", conflict_cnt, exp_conf6);

    // Requester 1 writes 7F, then requester 0 reads it back on the next grant.
    req_valid = 2'b10; req_wr = 2'b10; req_addr[13:7] = 7'h7F; req_wdata[15:8] = 8'h3C; #1;
    chk("t3_wr_ready", req_ready, 2'b10);
    tick();
    chk("t3_wr_en", mem_en, 1'b1);
    chk("t3_wr_wr", mem_wr, 1'b1);
    chk("t3_wr_addr", mem_addr, 7'h7F);
    chk("t3_wr_wdata", mem_wdata, 8'h3C);
    req_valid = 2'b01; req_wr = 2'b00; req_addr[6:0] = 7'h7F; #1;
    chk("t3_rd_ready", req_ready, 2'b01);
    tick();
    chk("t3_rd_en", mem_en, 1'b1);
    chk("t3_rd_wr", mem_wr, 1'b0);
    chk("t3_rd_addr", mem_addr, 7'h7F);
    chk("t3_wr_ack", rsp_valid, 2'b10);
    chk("t3_wr_old", rsp_rdata, 8'hBF);
    req_valid = 2'b00;
    tick();
    chk("t3_rd_rsp", rsp_valid, 2'b01);
    chk("t3_rd_data", rsp_rdata, 8'h3C);

    // Only requester 1 valid for 4 cycles: it is granted every cycle.
    req_addr[13:7] = 7'h03;
    for (int c = 0; c < 7; c++) begin
      req_valid = (c < 4) ? 2'b10 : 2'b00;
      #1;
      if (c < 4) chk("t4_ready", req_ready, 2'b10);
      if (c >= 1 && c <= 4) begin
        chk("t4_mem_en", mem_en, 1'b1);
        chk("t4_mem_addr", mem_addr, 7'h03);
      end
      if (c == 5) chk("t4_mem_en_off", mem_en, 1'b0);
      if (c >= 2 && c <= 5) begin
        chk("t4_rsp_valid", rsp_valid, 2'b10);
        chk("t4_rsp_rdata", rsp_rdata, 8'h43);
      end
      if (c == 6) chk("t4_rsp_off", rsp_valid, 2'b00);
      tick();
    end

    // Two reads accepted, then reset before either response is returned.
    req_valid = 2'b11; req_addr[6:0] = 7'h0A; req_addr[13:7] = 7'h14; #1;
    chk("t5_ready_a", req_ready, 2'b01);
    tick();
    chk("t5_ready_b", req_ready, 2'b10);
    tick();
    rst = 1'b1; #1;
    chk("t5_rst_ready", req_ready, 2'b00);
    chk("t5_rst_mem_en", mem_en, 1'b0);
    chk("t5_rst_mem_wr", mem_wr, 1'b0);
    chk("t5_rst_addr", mem_addr, 7'h00);
    chk("t5_rst_wdata", mem_wdata, 8'h00);
    chk("t5_rst_rsp", rsp_valid, 2'b00);
    chk("t5_rst_rdata", rsp_rdata, 8'h00);
    chk("t5_rst_conflict", conflict_cnt, 16'h0000);
    req_valid = 2'b00;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t5_no_rsp", rsp_valid, 2'b00);
      chk("t5_no_en", mem_en, 1'b0);
      tick();
    end
    req_valid = 2'b11; #1;
    chk("t5_first_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("t5_first_addr", mem_addr, 7'h0A);
    tick(); tick();

    // Contention counter: both requesters valid for 10 cycles after reset.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      req_valid = 2'b11;
      tick();
    end
    req_valid = 2'b00; #1;
    chk("t6_conflict", conflict_cnt, exp_conf10);
    tick();
    chk("t6_conflict_hold", conflict_cnt, exp_conf10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
